// File: rtl/per2axi_pkg.sv
// Shared types and AXI constants for the peripheral-to-AXI bridge.
// Imported by the bridge top and its lane mux.
package per2axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_B,
    READ,
    WAIT_R,
    RESP
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

endpackage

// File: rtl/per2axi_lane_mux.sv
// Maps a 32-bit peripheral word onto the AXI data bus and back.
// On a 64-bit bus, address bit 2 picks the upper or lower lane.
module per2axi_lane_mux
  import per2axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        lane_i,
  input  logic [31:0]                 wdata_i,
  input  logic [3:0]                  be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   rdata_i,
  output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] strb_o,
  output logic [31:0]                 rword_o
);

  if (AXI_DATA_WIDTH == 64) begin : g_w64
    assign wdata_o = {wdata_i, wdata_i};
    assign strb_o  = lane_i ? {be_i, 4'b0000}
                            : {4'b0000, be_i};
    assign rword_o = lane_i ? rdata_i[63:32]
                            : rdata_i[31:0];
  end else begin : g_w32
    logic unused_lane;
    assign unused_lane = lane_i;
    assign wdata_o     = wdata_i;
    assign strb_o      = be_i;
    assign rword_o     = rdata_i;
  end

endmodule

// File: rtl/per2axi_bridge.sv
// Peripheral slave to AXI4 master bridge: single-beat,
// one transaction in flight, response cannot be back-pressured.
module per2axi_bridge
  import per2axi_pkg::*;
#(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int AXI_ID_VALUE   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
  output logic                      per_slave_gnt_o,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic                      axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
  output logic [2:0]                axi_master_aw_prot_o,
  output logic [7:0]                axi_master_aw_len_o,
  output logic [2:0]                axi_master_aw_size_o,
  output logic [1:0]                axi_master_aw_burst_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_aw_user_o,
  input  logic                      axi_master_aw_ready_i,
  output logic                      axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_master_w_data_o,
  output logic [AXI_STRB_WIDTH-1:0] axi_master_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_w_user_o,
  output logic                      axi_master_w_last_o,
  input  logic                      axi_master_w_ready_i,
  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,
  output logic                      axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
  output logic [2:0]                axi_master_ar_prot_o,
  output logic [7:0]                axi_master_ar_len_o,
  output logic [2:0]                axi_master_ar_size_o,
  output logic [1:0]                axi_master_ar_burst_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_master_ar_user_o,
  input  logic                      axi_master_ar_ready_i,
  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o
);

  state_e                    state_q;
  logic [PER_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                be_q;
  logic [PER_ID_WIDTH-1:0]   id_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      ar_valid_q;
  logic                      b_ready_q;
  logic                      r_ready_q;
  logic                      r_valid_q;
  logic                      opc_q;
  logic [31:0]               rdata_q;
  logic [31:0]               rword;
  logic                      aw_done;
  logic                      w_done;
  logic                      unused_inputs;

  per2axi_lane_mux #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_lane_mux (
    .lane_i (addr_q[2]),
    .wdata_i(wdata_q),
    .be_i   (be_q),
    .rdata_i(axi_master_r_data_i),
    .wdata_o(axi_master_w_data_o),
    .strb_o (axi_master_w_strb_o),
    .rword_o(rword)
  );

  // A channel counts as done once its valid is gone or it handshakes now.
  assign aw_done = !aw_valid_q || axi_master_aw_ready_i;
  assign w_done  = !w_valid_q  || axi_master_w_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      id_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      opc_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      r_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (per_slave_req_i) begin
            addr_q  <= per_slave_add_i;
            wdata_q <= per_slave_wdata_i;
            be_q    <= per_slave_be_i;
            id_q    <= per_slave_id_i;
            if (per_slave_we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WRITE;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        WRITE: begin
          if (axi_master_aw_ready_i) aw_valid_q <= 1'b0;
          if (axi_master_w_ready_i)  w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready_q <= 1'b1;
            state_q   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (axi_master_b_valid_i) begin
            b_ready_q <= 1'b0;
            opc_q     <= axi_master_b_resp_i != AXI_RESP_OKAY;
            rdata_q   <= '0;
            r_valid_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        READ: begin
          if (axi_master_ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (axi_master_r_valid_i) begin
            r_ready_q <= 1'b0;
            opc_q     <= axi_master_r_resp_i != AXI_RESP_OKAY;
            rdata_q   <= rword;
            r_valid_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign per_slave_gnt_o     = (state_q == IDLE) && per_slave_req_i;
  assign per_slave_r_valid_o = r_valid_q;
  assign per_slave_r_opc_o   = opc_q;
  assign per_slave_r_rdata_o = rdata_q;
  assign per_slave_r_id_o    = id_q;

  assign axi_master_aw_valid_o = aw_valid_q;
  assign axi_master_aw_addr_o  = AXI_ADDR_WIDTH'(addr_q);
  assign axi_master_aw_prot_o  = 3'b000;
  assign axi_master_aw_len_o   = 8'd0;
  assign axi_master_aw_size_o  = SIZE_4B;
  assign axi_master_aw_burst_o = BURST_INCR;
  assign axi_master_aw_id_o    = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_master_aw_user_o  = '0;

  assign axi_master_w_valid_o = w_valid_q;
  assign axi_master_w_user_o  = '0;
  assign axi_master_w_last_o  = 1'b1;
  assign axi_master_b_ready_o = b_ready_q;

  assign axi_master_ar_valid_o = ar_valid_q;
  assign axi_master_ar_addr_o  = AXI_ADDR_WIDTH'(addr_q);
  assign axi_master_ar_prot_o  = 3'b000;
  assign axi_master_ar_len_o   = 8'd0;
  assign axi_master_ar_size_o  = SIZE_4B;
  assign axi_master_ar_burst_o = BURST_INCR;
  assign axi_master_ar_id_o    = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_master_ar_user_o  = '0;
  assign axi_master_r_ready_o  = r_ready_q;

  assign unused_inputs = ^{axi_master_b_id_i, axi_master_b_user_i,
                           axi_master_r_last_i, axi_master_r_id_i,
                           axi_master_r_user_i};

endmodule

// File: tb/tb_per2axi_bridge.sv
// Directed bench: scripted AXI slave plus a transaction-level
// model of grant/response timing checked every cycle.
module tb_per2axi_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req, we, gnt;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic [4:0]  id;
  logic        r_valid_o, r_opc;
  logic [31:0] r_rdata;
  logic [4:0]  r_id;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_prot, aw_size, ar_prot, ar_size, aw_id, ar_id, b_id, r_id_i;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [5:0]  aw_user, ar_user, w_user, b_user, r_user;
  logic [63:0] w_data, r_data;
  logic        b_valid, b_ready, ar_valid, ar_ready;
  logic        r_valid, r_last, r_ready;

  always #5 clk = ~clk;

  per2axi_bridge dut (
    .clk_i(clk), .rst_i(rst_i),
    .per_slave_req_i(req), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_wdata_i(wdata),
    .per_slave_be_i(be), .per_slave_id_i(id),
    .per_slave_gnt_o(gnt), .per_slave_r_valid_o(r_valid_o),
    .per_slave_r_opc_o(r_opc), .per_slave_r_rdata_o(r_rdata),
    .per_slave_r_id_o(r_id),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
    .axi_master_aw_prot_o(aw_prot), .axi_master_aw_len_o(aw_len),
    .axi_master_aw_size_o(aw_size), .axi_master_aw_burst_o(aw_burst),
    .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
    .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
    .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
    .axi_master_b_id_i(b_id), .axi_master_b_user_i(b_user),
    .axi_master_b_ready_o(b_ready),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
    .axi_master_ar_prot_o(ar_prot), .axi_master_ar_len_o(ar_len),
    .axi_master_ar_size_o(ar_size), .axi_master_ar_burst_o(ar_burst),
    .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
    .axi_master_ar_ready_i(ar_ready),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data),
    .axi_master_r_resp_i(r_resp), .axi_master_r_last_i(r_last),
    .axi_master_r_id_i(r_id_i), .axi_master_r_user_i(r_user),
    .axi_master_r_ready_o(r_ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Slave behaviour knobs and per-transaction handshake record
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [63:0] r_data_cfg;
  int aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
  int aw_n, w_n, b_n, ar_n, r_n;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int resp_due;

  function automatic void clear_txn();
    aw_cyc = -1; w_cyc = -1; b_cyc = -1; ar_cyc = -1; r_cyc = -1;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    resp_due = -1;
  endfunction

  initial begin : slave
    cyc = 0;
    clear_txn();
    aw_ready = 0; w_ready = 0; ar_ready = 0;
    b_valid = 0; b_resp = 0; b_id = 0; b_user = 0;
    r_valid = 0; r_data = 0; r_resp = 0; r_last = 1;
    r_id_i = 0; r_user = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; r_valid = 0;
        clear_txn();
      end else begin
        if (b_valid && b_cyc >= 0 && b_cyc < cyc) b_valid = 0;
        if (aw_cyc >= 0 && w_cyc >= 0 && b_cyc < 0 && !b_valid) begin
          if (b_wait >= b_dly) begin
            b_valid = 1; b_resp = b_resp_cfg;
          end else b_wait++;
        end
        if (b_valid && b_ready && b_cyc < 0) begin
          b_cyc = cyc; b_n++; resp_due = cyc + 1;
        end
        if (r_valid && r_cyc >= 0 && r_cyc < cyc) r_valid = 0;
        if (ar_cyc >= 0 && r_cyc < 0 && !r_valid) begin
          if (r_wait >= r_dly) begin
            r_valid = 1; r_data = r_data_cfg; r_resp = r_resp_cfg;
          end else r_wait++;
        end
        if (r_valid && r_ready && r_cyc < 0) begin
          r_cyc = cyc; r_n++; resp_due = cyc + 1;
        end
        aw_ready = aw_valid && (aw_wait >= aw_dly);
        if (aw_valid && !aw_ready) aw_wait++;
        if (aw_valid && aw_ready) begin
          aw_n++; if (aw_cyc < 0) aw_cyc = cyc;
        end
        w_ready = w_valid && (w_wait >= w_dly);
        if (w_valid && !w_ready) w_wait++;
        if (w_valid && w_ready) begin
          w_n++; if (w_cyc < 0) w_cyc = cyc;
        end
        ar_ready = ar_valid && (ar_wait >= ar_dly);
        if (ar_valid && !ar_ready) ar_wait++;
        if (ar_valid && ar_ready) begin
          ar_n++; if (ar_cyc < 0) ar_cyc = cyc;
        end
      end
    end
  end

  // Transaction-level model of the bridge
  logic        busy, e_we;
  int          g_cyc, resp_cnt, resp_cyc;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic [4:0]  e_id, l_id;
  logic        l_opc;
  logic [31:0] l_rdata, cap_aw_addr, cap_ar_addr;
  logic [63:0] cap_w_data;
  logic [7:0]  cap_w_strb;

  initial begin : compare
    logic e_aw, e_w, e_ar, e_b, e_r, e_rv;
    int lane, wmax;
    logic [63:0] e_rd64, e_strb;
    busy = 0; resp_cnt = 0; resp_cyc = 0; g_cyc = 0;
    e_we = 0; e_addr = 0; e_wd = 0; e_be = 0; e_id = 0;
    forever begin
      @(negedge clk); #1;
      if (rst_i) begin
        chk("rst_ctrl", {gnt, aw_valid, w_valid, ar_valid, b_ready,
                         r_ready, r_valid_o, r_opc}, 0);
        chk("rst_rsp", {r_rdata, r_id}, 0);
        busy = 0;
      end else begin
        lane = int'(e_addr[2]);
        wmax = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        e_aw = busy && e_we && cyc > g_cyc &&
               (aw_cyc < 0 || aw_cyc == cyc);
        e_w  = busy && e_we && cyc > g_cyc &&
               (w_cyc < 0 || w_cyc == cyc);
        e_ar = busy && !e_we && cyc > g_cyc &&
               (ar_cyc < 0 || ar_cyc == cyc);
        e_b  = busy && e_we && aw_cyc >= 0 && w_cyc >= 0 &&
               cyc > wmax && (b_cyc < 0 || b_cyc == cyc);
        e_r  = busy && !e_we && ar_cyc >= 0 && cyc > ar_cyc &&
               (r_cyc < 0 || r_cyc == cyc);
        e_rv = busy && cyc == resp_due;
        chk("gnt", gnt, req && !busy);
        chk("aw_valid", aw_valid, e_aw);
        chk("w_valid", w_valid, e_w);
        chk("ar_valid", ar_valid, e_ar);
        chk("b_ready", b_ready, e_b);
        chk("r_ready", r_ready, e_r);
        chk("r_valid", r_valid_o, e_rv);
        if (aw_valid) begin
          cap_aw_addr = aw_addr;
          chk("aw_addr", aw_addr, e_addr);
          chk("aw_fixed", {aw_len, aw_size, aw_burst, aw_prot, aw_id,
                           aw_user}, {8'd0, 3'd2, 2'd1, 3'd0, 3'd0, 6'd0});
        end
        if (w_valid) begin
          cap_w_data = w_data;
          cap_w_strb = w_strb;
          e_strb = 64'(e_be) * ((lane == 1) ? 64'd16 : 64'd1);
          chk("w_data", w_data, {e_wd, e_wd});
          chk("w_strb", w_strb, e_strb);
          chk("w_fixed", {w_last, w_user}, {1'b1, 6'd0});
        end
        if (ar_valid) begin
          cap_ar_addr = ar_addr;
          chk("ar_addr", ar_addr, e_addr);
          chk("ar_fixed", {ar_len, ar_size, ar_burst, ar_prot, ar_id,
                           ar_user}, {8'd0, 3'd2, 2'd1, 3'd0, 3'd0, 6'd0});
        end
        if (r_valid_o) begin
          e_rd64 = r_data_cfg >> (32 * lane);
          chk("r_id", r_id, e_id);
          chk("r_opc", r_opc, e_we ? (b_resp_cfg != 2'b00)
                                   : (r_resp_cfg != 2'b00));
          chk("r_rdata", r_rdata, e_we ? 64'd0 : {32'd0, e_rd64[31:0]});
          if (e_we) chk("wr_hs_count", aw_n * 100 + w_n * 10 + b_n, 111);
          else      chk("rd_hs_count", ar_n * 10 + r_n, 11);
          resp_cnt++; resp_cyc = cyc;
          l_opc = r_opc; l_rdata = r_rdata; l_id = r_id;
        end
        if (e_rv) busy = 0;
        if (gnt && req) begin
          busy = 1; g_cyc = cyc;
          e_we = we; e_addr = add; e_wd = wdata; e_be = be; e_id = id;
          clear_txn();
        end
      end
    end
  end

  task automatic set_slave(input int awd, input int wd, input int bd,
                           input int ard, input int rd,
                           input logic [1:0] br, input logic [1:0] rr,
                           input logic [63:0] rdat);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    b_resp_cfg = br; r_resp_cfg = rr; r_data_cfg = rdat;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [4:0] i, input bit hold);
    int k;
    @(posedge clk); #1;
    req = 1; we = w; add = a; wdata = d; be = b; id = i;
    k = 0;
    @(negedge clk); #2;
    while (!gnt && k < 60) begin
      @(negedge clk); #2; k++;
    end
    chk("grant_seen", gnt, 1);
    @(posedge clk); #1;
    if (!hold) req = 0;
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while (resp_cnt < n && k < 100) begin
      @(negedge clk); #2; k++;
    end
    chk("resp_seen", resp_cnt >= n, 1);
  endtask

  initial begin : main
    int r1, k;
    rst_i = 1; req = 0; we = 0; add = 0; wdata = 0; be = 0; id = 0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    repeat (2) @(negedge clk);
    #2 rst_i = 0;

    issue(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 5'd3, 0);
    wait_resp(1);
    chk("t1_aw_addr", cap_aw_addr, 64'h1000_0004);
    chk("t1_w_strb", cap_w_strb, 64'hF0);
    chk("t1_w_data", cap_w_data, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("t1_resp", {l_opc, l_id, l_rdata}, {1'b0, 5'd3, 32'd0});
    chk("t1_latency", resp_cyc - g_cyc, 3);

    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h1111_2222_3333_4444);
    issue(0, 32'h2000_0000, 32'h0, 4'hF, 5'd7, 0);
    wait_resp(2);
    chk("t2_ar_addr", cap_ar_addr, 64'h2000_0000);
    chk("t2_rdata", l_rdata, 64'h3333_4444);
    chk("t2_opc_id", {l_opc, l_id}, {1'b0, 5'd7});
    chk("t2_latency", resp_cyc - g_cyc, 3);
    issue(0, 32'h2000_0004, 32'h0, 4'hF, 5'd8, 0);
    wait_resp(3);
    chk("t3_rdata", l_rdata, 64'h1111_2222);

    set_slave(3, 1, 0, 0, 0, 2'b00, 2'b00, 64'h0);
    issue(1, 32'h3000_0000, 32'hCAFE_F00D, 4'h3, 5'd9, 0);
    wait_resp(4);
    chk("t4_w_strb", cap_w_strb, 64'h03);
    chk("t4_w_first", w_cyc - g_cyc, 2);
    chk("t4_aw_late", aw_cyc - g_cyc, 4);
    chk("t4_latency", resp_cyc - g_cyc, 6);

    set_slave(0, 0, 0, 0, 2, 2'b00, 2'b10, 64'hAAAA_5555_0000_FFFF);
    issue(0, 32'h4000_0004, 32'h0, 4'hF, 5'd12, 0);
    wait_resp(5);
    chk("t5_slverr", {l_opc, l_rdata}, {1'b1, 32'hAAAA_5555});

    set_slave(0, 0, 2, 0, 0, 2'b11, 2'b00, 64'h0);
    issue(1, 32'h4000_0010, 32'h1234_5678, 4'h1, 5'd13, 0);
    wait_resp(6);
    chk("t6_decerr", {l_opc, l_rdata}, {1'b1, 32'd0});

    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h1111_2222_3333_4444);
    issue(1, 32'h5000_0008, 32'h1234_5678, 4'hC, 5'd1, 1);
    we = 0; add = 32'h5000_000C; id = 5'd2;
    wait_resp(7);
    r1 = resp_cyc;
    k = 0;
    while (!gnt && k < 20) begin
      @(negedge clk); #2; k++;
    end
    chk("t7_regrant_cycle", cyc, r1 + 1);
    @(posedge clk); #1;
    req = 0;
    wait_resp(8);
    chk("t7_second", {l_id, l_rdata}, {5'd2, 32'h1111_2222});

    set_slave(0, 0, 0, 0, 5, 2'b00, 2'b00, 64'h9999_8888_7777_6666);
    issue(0, 32'h6000_0000, 32'h0, 4'hF, 5'd20, 0);
    k = 0;
    @(negedge clk); #2;
    while (!r_ready && k < 20) begin
      @(negedge clk); #2; k++;
    end
    chk("t8_in_wait_r", r_ready, 1);
    rst_i = 1;
    @(negedge clk); #2;
    chk("t8_after_rst", {r_ready, ar_valid, r_valid_o}, 0);
    rst_i = 0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 64'h0BAD_0000_600D_0001);
    issue(0, 32'h6000_0000, 32'h0, 4'hF, 5'd21, 0);
    wait_resp(9);
    chk("t8_fresh", {l_opc, l_id, l_rdata}, {1'b0, 5'd21, 32'h600D_0001});
    chk("t8_resp_total", resp_cnt, 9);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/per2axi_bridge.md
Name: per2axi_bridge

Overview:
- Peripheral-interconnect slave to AXI4 master bridge. It converts single 32-bit peripheral requests into single-beat AXI reads and writes.
- Mirror of the AXI-to-peripheral path. It sits on the cluster peripheral interconnect and lets peripheral masters reach the SoC AXI fabric.
- One transaction is outstanding at a time.
- AXI region/lock/cache/qos are not generated; they are tied to 0 at integration.

Parameters:
PER_ADDR_WIDTH, 32, peripheral address width
PER_ID_WIDTH, 5, peripheral transaction ID width
AXI_ADDR_WIDTH, 32, AXI address width (must be >= PER_ADDR_WIDTH)
AXI_DATA_WIDTH, 64, AXI data width; only 32 and 64 are legal
AXI_ID_WIDTH, 3, AXI ID width
AXI_USER_WIDTH, 6, AXI user width
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width
AXI_ID_VALUE, 0, constant AWID/ARID value

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
per_slave_req_i/add_i/we_i/wdata_i/be_i/id_i  in  1/PER_ADDR_WIDTH/1/32/4/PER_ID_WIDTH  peripheral request
per_slave_gnt_o  out  1  request accepted
per_slave_r_valid_o/r_opc_o/r_rdata_o/r_id_o  out  1/1/32/PER_ID_WIDTH  peripheral response; opc=1 means error
axi_master_aw_valid_o/addr_o/prot_o/len_o/size_o/burst_o/id_o/user_o  out  1/AXI_ADDR_WIDTH/3/8/3/2/AXI_ID_WIDTH/AXI_USER_WIDTH  write address
axi_master_aw_ready_i  in  1  write address accepted
axi_master_w_valid_o/data_o/strb_o/user_o/last_o  out  1/AXI_DATA_WIDTH/AXI_STRB_WIDTH/AXI_USER_WIDTH/1  write data
axi_master_w_ready_i  in  1  write data accepted
axi_master_b_valid_i/resp_i/id_i/user_i  in  1/2/AXI_ID_WIDTH/AXI_USER_WIDTH  write response
axi_master_b_ready_o  out  1  write response ready
axi_master_ar_valid_o/addr_o/prot_o/len_o/size_o/burst_o/id_o/user_o  out  same widths as AW  read address
axi_master_ar_ready_i  in  1  read address accepted
axi_master_r_valid_i/data_i/resp_i/last_i/id_i/user_i  in  1/AXI_DATA_WIDTH/2/1/AXI_ID_WIDTH/AXI_USER_WIDTH  read data
axi_master_r_ready_o  out  1  read data ready

Behaviour:
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP. Reset enters IDLE.
- Reset values: all valid outputs 0, gnt 0, b_ready 0, r_ready 0, r_opc 0; registered data/address/id outputs 0.
- IDLE: gnt_o = req_i, combinationally. On req, the bridge latches add, we, wdata, be, id and goes to WRITE (we=1) or READ (we=0). gnt is low in every other state.
- Fixed AXI fields: len=0, size=3'b010, burst=INCR, prot=0, user=0, w_last=1, id=AXI_ID_VALUE. addr is the latched add, zero-extended.
- Lane rule for 64-bit data:
  - lane = add[2].
  - w_data = {wdata,wdata}.
  - w_strb = be<<(4*lane).
  - Read result is r_data[32*lane +: 32].
  - For 32-bit AXI, lane is ignored.
- WRITE: aw_valid and w_valid assert together the cycle after grant. Each drops independently on its own ready; the two handshakes may complete in either order or the same cycle. Both done -> WAIT_B.
- WAIT_B: b_ready=1. On b_valid, latch opc=(b_resp!=OKAY) and rdata=0, then go to RESP.
- READ: ar_valid=1 until ar_ready, then WAIT_R.
- WAIT_R: r_ready=1. On r_valid, latch the lane data and opc=(r_resp!=OKAY), then go to RESP. r_last is not checked.
- RESP: r_valid_o=1 for exactly one cycle with the latched id, then IDLE. The response cannot be back-pressured.
- Minimum latency, with all readies high:
  - Write: grant at T, AW/W at T+1, B at T+2 at the earliest, r_valid_o at T+3.
  - Read: the same, with AR/R in place of AW/W/B.
- A new req_i is not granted until the cycle after RESP.
- AXI valids never drop before their handshake completes. Payload is stable while valid is high.
- Stray b_valid or r_valid outside WAIT_B/WAIT_R is ignored; ready is low then, so no handshake occurs.
- Reset mid-transaction: returns to IDLE immediately and drops all valids. Any partial AXI handshake is abandoned; the system must reset both ends together.

Decomposition:
- per2axi_pkg holds the state enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, and the SIZE_4B constant.
- One sub-module, per2axi_lane_mux: combinational write replication, strobe shift and read lane extraction, parameterised by AXI_DATA_WIDTH.

Test Plan:
- Write add=0x1000_0004, wdata=0xDEADBEEF, be=0xF, id=3, all readies 1 -> checks:
  - aw_addr=0x1000_0004; w_strb=0xF0; w_data=0xDEADBEEF_DEADBEEF.
  - B OKAY gives r_valid_o=1, r_opc=0, r_id=3 at grant+3.
- Read add=0x2000_0000 with r_data=0x11112222_33334444 -> r_rdata=0x33334444, opc=0. Repeat with add=0x2000_0004 -> 0x11112222.
- Write with aw_ready delayed 3 cycles and w_ready delayed 1 -> W handshakes first; aw_valid stays high until its ready; exactly one B accepted, one response.
- Read with r_resp=SLVERR -> r_opc=1. Write with b_resp=DECERR -> r_opc=1, r_rdata=0.
- Back-to-back requests held on req_i -> second gnt only in the cycle after the first r_valid_o; no overlapping AXI transactions.
- Assert rst_i while in WAIT_R -> next cycle: IDLE, all valids 0, r_ready 0; a fresh read completes normally.
